// File: rtl/lsu_read_path.sv
// Load/store unit read path: decodes the load address, captures peripheral data,
// and returns an aligned, extended load result exactly one cycle after the request.
module lsu_read_path #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_rd_en,
  input  logic [15:0] i_lsu_addr,
  input  logic [2:0]  i_ld_size,
  input  logic [31:0] i_dmem_rdata,
  input  logic [31:0] i_op_rdata,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_ld_err
);

  logic [31:0] sync_r [SYNC_STAGES];

  logic        is_dmem_s;
  logic        is_op_s;
  logic        is_ip_s;
  logic        ip_word0_s;
  logic        size_bad_s;
  logic        misalign_s;
  logic        err_s;
  logic [31:0] cap_word_s;

  logic        s1_valid_r;
  logic        s1_dmem_r;
  logic        s1_err_r;
  logic [1:0]  s1_off_r;
  logic [2:0]  s1_size_r;
  logic [31:0] s1_word_r;

  logic [31:0] raw_word_s;
  logic        valid_s;

  // Lane select and sign/zero extension of a raw word for a given funct3.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, b};
      3'b101:  res = {16'h0000, h};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Switch synchronizer chain; IP loads only ever see the last stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 32'h0000_0000;
      end
    end else begin
      sync_r[0] <= i_io_sw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Request-cycle decode: region, size legality, alignment and captured word.
  always_comb begin
    is_dmem_s  = (i_lsu_addr[15:13] == 3'b001);
    is_op_s    = (i_lsu_addr[15:6] == 10'b0111_0000_00);
    is_ip_s    = (i_lsu_addr[15:5] == 11'b0111_1000_000);
    ip_word0_s = (i_lsu_addr[4:2] == 3'b000);
    size_bad_s = 1'b0;
    misalign_s = 1'b0;
    case (i_ld_size)
      3'b000, 3'b100: misalign_s = 1'b0;
      3'b001, 3'b101: misalign_s = i_lsu_addr[0];
      3'b010:         misalign_s = (i_lsu_addr[1:0] != 2'b00);
      default:        size_bad_s = 1'b1;
    endcase
    err_s = !(is_dmem_s || is_op_s || is_ip_s) || size_bad_s || misalign_s;
    // Only the first IP word carries switches; the rest of the window reads zero.
    if (is_op_s) begin
      cap_word_s = i_op_rdata;
    end else if (is_ip_s && ip_word0_s) begin
      cap_word_s = sync_r[SYNC_STAGES-1];
    end else begin
      cap_word_s = 32'h0000_0000;
    end
  end

  // Stage-1 register bridging the request cycle and the response cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_dmem_r  <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_off_r   <= 2'b00;
      s1_size_r  <= 3'b000;
      s1_word_r  <= 32'h0000_0000;
    end else begin
      s1_valid_r <= i_lsu_rd_en;
      if (i_lsu_rd_en) begin
        s1_dmem_r <= is_dmem_s;
        s1_err_r  <= err_s;
        s1_off_r  <= i_lsu_addr[1:0];
        s1_size_r <= i_ld_size;
        s1_word_r <= cap_word_s;
      end
    end
  end

  // Response formatting; reset low kills an in-flight response in its own cycle.
  always_comb begin
    valid_s = s1_valid_r && i_rst_n;
    if (s1_dmem_r) begin
      raw_word_s = i_dmem_rdata;
    end else begin
      raw_word_s = s1_word_r;
    end
    if (valid_s && !s1_err_r) begin
      o_ld_data = extend_load(raw_word_s, s1_off_r, s1_size_r);
    end else begin
      o_ld_data = 32'h0000_0000;
    end
    o_ld_valid = valid_s;
    o_ld_err   = valid_s && s1_err_r;
  end

endmodule

// File: tb/tb_lsu_read_path.sv
// Directed bench for lsu_read_path: table of single loads plus reset,
// synchronizer-latency and back-to-back sequences.
module tb_lsu_read_path;

  logic        clk;
  logic        rst_n;
  logic        rd_en;
  logic [15:0] addr;
  logic [2:0]  size;
  logic [31:0] dmem;
  logic [31:0] op;
  logic [31:0] sw;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_ld_err;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  typedef struct {
    logic [2:0]  sz;
    logic [15:0] a;
    logic [31:0] dm;
    logic [31:0] op;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  lsu_read_path #(.SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_rd_en  (rd_en),
    .i_lsu_addr   (addr),
    .i_ld_size    (size),
    .i_dmem_rdata (dmem),
    .i_op_rdata   (op),
    .i_io_sw      (sw),
    .o_ld_data    (o_ld_data),
    .o_ld_valid   (o_ld_valid),
    .o_ld_err     (o_ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic step(input logic r, input logic rd, input logic [2:0] sz, input logic [15:0] a,
                      input logic [31:0] o, input logic [31:0] dm, input logic [31:0] s);
    @(negedge clk);
    rst_n = r;
    rd_en = rd;
    size  = sz;
    addr  = a;
    op    = o;
    dmem  = dm;
    sw    = s;
    #2;
  endtask

  task automatic chk(input string nm, input logic ev, input logic [31:0] ed, input logic ee);
    n_cmp++;
    if (o_ld_valid !== ev || o_ld_data !== ed || o_ld_err !== ee) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b data=%h err=%0b, expected valid=%0b data=%h err=%0b",
               nm, o_ld_valid, o_ld_data, o_ld_err, ev, ed, ee);
    end
  endtask

  task automatic add(input logic [2:0] sz, input logic [15:0] a, input logic [31:0] dm,
                     input logic [31:0] o, input logic [31:0] ed, input logic ee);
    vec_t v;
    v.sz = sz; v.a = a; v.dm = dm; v.op = o; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endtask

  localparam logic [31:0] SWV = 32'h8F0F_0F0F;
  localparam logic [31:0] GOP = 32'h6666_6666;
  localparam logic [31:0] GDM = 32'h5555_5555;
  localparam logic [31:0] SW2 = 32'h0000_0F0F;

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; addr = 16'h0000; size = 3'b000;
    dmem = 32'h0; op = 32'h0; sw = 32'h0;

    // DMEM lanes and extension
    add(LW,  16'h2004, 32'hDEAD_BEEF, GOP, 32'hDEAD_BEEF, 1'b0);
    add(LB,  16'h2003, 32'h80FF_1234, GOP, 32'hFFFF_FF80, 1'b0);
    add(LBU, 16'h2003, 32'h80FF_1234, GOP, 32'h0000_0080, 1'b0);
    add(LH,  16'h2002, 32'h80FF_1234, GOP, 32'hFFFF_80FF, 1'b0);
    add(LHU, 16'h2002, 32'h80FF_1234, GOP, 32'h0000_80FF, 1'b0);
    add(LB,  16'h2000, 32'h80FF_1234, GOP, 32'h0000_0034, 1'b0);
    add(LB,  16'h2001, 32'h80FF_1234, GOP, 32'h0000_0012, 1'b0);
    add(LBU, 16'h2002, 32'h80FF_1234, GOP, 32'h0000_00FF, 1'b0);
    add(LH,  16'h2000, 32'h80FF_1234, GOP, 32'h0000_1234, 1'b0);
    add(LH,  16'h3FFE, 32'h8001_0000, GOP, 32'hFFFF_8001, 1'b0);
    // OP region
    add(LW,  16'h7010, GDM, 32'h0000_00A5, 32'h0000_00A5, 1'b0);
    add(LB,  16'h703F, GDM, 32'h1234_5678, 32'h0000_0012, 1'b0);
    add(LHU, 16'h7002, GDM, 32'hABCD_0000, 32'h0000_ABCD, 1'b0);
    // IP region
    add(LW,  16'h7800, GDM, GOP, SWV,          1'b0);
    add(LB,  16'h7803, GDM, GOP, 32'hFFFF_FF8F, 1'b0);
    add(LW,  16'h7804, GDM, GOP, 32'h0000_0000, 1'b0);
    add(LBU, 16'h781F, GDM, GOP, 32'h0000_0000, 1'b0);
    // errors
    add(LW,  16'h7040, GDM, GOP, 32'h0, 1'b1);
    add(LW,  16'h7820, GDM, GOP, 32'h0, 1'b1);
    add(LW,  16'h4000, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);
    add(LW,  16'h1FFC, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);
    add(LW,  16'h2002, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);
    add(LH,  16'h7001, GDM, 32'hDEAD_BEEF, 32'h0, 1'b1);
    add(LHU, 16'h2001, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);
    add(3'b011, 16'h2000, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);
    add(3'b110, 16'h2000, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);
    add(3'b111, 16'h2000, 32'hDEAD_BEEF, GOP, 32'h0, 1'b1);

    // reset state
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, LW, 16'h2000, GOP, GDM, SWV);
    chk("reset_state", 1'b0, 32'h0, 1'b0);

    // table, pipelined back-to-back
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i < vecs.size()) begin
        step(1'b1, 1'b1, vecs[i].sz, vecs[i].a, vecs[i].op,
             (i > 0) ? vecs[i-1].dm : 32'h0, SWV);
      end else begin
        step(1'b1, 1'b0, LW, 16'h0000, GOP, vecs[i-1].dm, SWV);
      end
      if (i > 0) chk($sformatf("vec%0d_%h", i - 1, vecs[i-1].a), 1'b1, vecs[i-1].ed, vecs[i-1].ee);
    end
    step(1'b1, 1'b0, LW, 16'h2000, GOP, GDM, SWV);
    chk("idle", 1'b0, 32'h0, 1'b0);

    // request during reset is discarded
    step(1'b0, 1'b1, LW, 16'h2000, GOP, GDM, SWV);
    step(1'b1, 1'b0, LW, 16'h2000, GOP, 32'h1111_1111, SWV);
    chk("req_in_reset", 1'b0, 32'h0, 1'b0);

    // accepted request dropped by reset in the response cycle
    step(1'b1, 1'b1, LW, 16'h2004, GOP, GDM, SWV);
    step(1'b0, 1'b0, LW, 16'h2000, GOP, 32'hDEAD_BEEF, SWV);
    chk("drop_n1", 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, LW, 16'h2000, GOP, 32'hDEAD_BEEF, SWV);
    chk("drop_n2", 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, LW, 16'h2008, GOP, GDM, SWV);
    step(1'b1, 1'b0, LW, 16'h2000, GOP, 32'hCAFE_F00D, SWV);
    chk("first_after_rst", 1'b1, 32'hCAFE_F00D, 1'b0);

    // switches toggling during reset must not leak out
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, LW, 16'h7800, GOP, GDM, (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678);
    end
    step(1'b1, 1'b1, LW, 16'h7800, GOP, GDM, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, LW, 16'h7800, GOP, GDM, 32'hFFFF_FFFF);
    chk("ip_after_rst", 1'b1, 32'h0, 1'b0);
    step(1'b1, 1'b0, LW, 16'h7800, GOP, GDM, 32'hFFFF_FFFF);

    // synchronizer latency, then OP/IP back-to-back
    step(1'b1, 1'b1, LW, 16'h7800, GOP, GDM, SW2);
    chk("pre_seq_idle", 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, LW, 16'h7800, GOP, GDM, SW2);
    chk("sync_c0", 1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 1'b1, LW, 16'h7800, GOP, GDM, SW2);
    chk("sync_c1", 1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 1'b1, LW, 16'h7010, 32'h0000_00A5, GDM, SW2);
    chk("sync_c2", 1'b1, SW2, 1'b0);
    step(1'b1, 1'b1, LW, 16'h7800, GOP, GDM, SW2);
    chk("b2b_op", 1'b1, 32'h0000_00A5, 1'b0);
    step(1'b1, 1'b0, LW, 16'h7800, GOP, GDM, SW2);
    chk("b2b_ip", 1'b1, SW2, 1'b0);
    step(1'b1, 1'b0, LW, 16'h7800, GOP, GDM, SW2);
    chk("final_idle", 1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_read_path.md
LSU_READ_PATH -- requirements
Module: lsu_read_path

Interface
REQ-001 The block SHALL have exactly one parameter: SYNC_STAGES, default 2, the number of flops in the synchronizer on i_io_sw (legal range 2..4).
REQ-002 The block SHALL have the following ports:
  i_clk         in   1   single clock; all state updates on its rising edge.
  i_rst_n       in   1   reset, synchronous, active-low.
  i_lsu_rd_en   in   1   load request this cycle.
  i_lsu_addr    in   16  byte address of the load.
  i_ld_size     in   3   funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  i_dmem_rdata  in   32  data memory read word; valid the cycle after the request.
  i_op_rdata    in   32  output-peripheral readback word; valid in the request cycle.
  i_io_sw       in   32  raw asynchronous switch/key inputs.
  o_ld_data     out  32  aligned, extended load result.
  o_ld_valid    out  1   o_ld_data and o_ld_err valid this cycle.
  o_ld_err      out  1   load was unmapped, misaligned or had an illegal size.

Function
REQ-003 Address decode SHALL be:
  - DMEM: addr[15:13]==3'b001 (0x2000-0x3FFF).
  - OP: addr[15:6]==10'b0111_0000_00 (0x7000-0x703F).
  - IP: addr[15:5]==11'b0111_1000_000 (0x7800-0x781F).
  - Any other address is unmapped.
REQ-004 Fixed latency SHALL be 1 cycle: o_ld_valid=1 in cycle N+1 if and only if i_lsu_rd_en=1 in cycle N.
REQ-005 Back-to-back requests every cycle SHALL be accepted, with no stall and no bubble.
REQ-006 In the request cycle, the stage-1 register SHALL capture: region, addr[1:0], i_ld_size, i_op_rdata (if OP) or the synchronized switch word (if IP), and the error flag.
REQ-007 In the response cycle, the raw word SHALL be: i_dmem_rdata for DMEM, or the captured word for OP and IP.
REQ-008 Byte loads (LB/LBU) SHALL select byte lane addr[1:0]: 00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24].
REQ-009 Halfword loads (LH/LHU) SHALL select half lane addr[1]: 0 -> [15:0], 1 -> [31:16].
REQ-010 LB and LH SHALL sign-extend to 32 bits; LBU and LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-011 o_ld_err SHALL be 1 when any of the following holds:
  - the address is unmapped;
  - i_ld_size is 011, 110 or 111;
  - the load is LH/LHU with addr[0]=1;
  - the load is LW with addr[1:0]!=00.
REQ-012 When o_ld_err=1, o_ld_data SHALL be 32'h0.
REQ-013 When o_ld_valid=0, o_ld_data SHALL be 32'h0 and o_ld_err SHALL be 0.
REQ-014 i_io_sw SHALL pass through a SYNC_STAGES-deep flop chain; IP loads SHALL return the last chain stage, so a switch change is visible no earlier than SYNC_STAGES cycles later.
REQ-015 Within the IP region, only word offset 0x7800 SHALL return switch data; 0x7804-0x781F SHALL return 32'h0 with o_ld_err=0.
REQ-016 The block SHALL not drive any memory or peripheral enable; it observes read data only.

Reset
REQ-017 While i_rst_n=0 at a clock edge, all of the following SHALL clear on that edge:
  - the stage-1 register;
  - the synchronizer chain;
  - o_ld_valid, o_ld_err and o_ld_data (all 0).
REQ-018 A request presented in the same cycle that i_rst_n=0 SHALL be discarded: no o_ld_valid on the following cycle.
REQ-019 A request accepted in cycle N, followed by reset asserted in cycle N+1, SHALL produce o_ld_valid=0 in N+1 onward (the response is dropped).
REQ-020 The first request after reset deassertion SHALL respond normally, 1 cycle later.

Verification
REQ-021 LW at 0x2004 with i_dmem_rdata=32'hDEAD_BEEF in the next cycle -> o_ld_valid=1, o_ld_data=32'hDEADBEEF, o_ld_err=0.
REQ-022 LB at 0x2003 and LBU at 0x2003, both with i_dmem_rdata=32'h80FF_1234:
  - LB -> 32'hFFFF_FF80.
  - LBU -> 32'h0000_0080.
  - LH at 0x2002 -> 32'hFFFF_80FF.
REQ-023 LW at 0x7010 with i_op_rdata=32'h0000_00A5, followed back-to-back by LW at 0x7800 after i_io_sw has been held at 32'h0000_0F0F for 3 or more cycles -> two consecutive valid cycles returning 32'h000000A5 then 32'h00000F0F.
REQ-024 Error loads, each -> o_ld_err=1 and o_ld_data=0:
  - LW at 0x4000 (unmapped);
  - LW at 0x2002 (misaligned);
  - LH at 0x7001 (misaligned);
  - i_ld_size=3'b011 at 0x2000 (illegal size).
REQ-025 Reset cases:
  - request in cycle N with i_rst_n=0 in cycle N+1 -> o_ld_valid=0 in N+1 and N+2;
  - i_io_sw toggled during reset -> IP read immediately after reset returns 32'h0.
